imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: takes a length header plus big-endian words
// over a byte handshake, writes them sequentially, and stalls the CPU until done.
module imem_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MAX_WORDS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              overflow,
  output logic [15:0]       word_count
);

  // state  | meaning
  // IDLE   | after reset, waiting for start, CPU held
  // LEN_HI | waiting for length header high byte
  // LEN_LO | waiting for length header low byte
  // DATA   | collecting the four bytes of a word, MSB first
  // WRITE  | one-cycle memory write of the assembled word (no byte accepted)
  // DONE   | load finished, CPU released, start may begin a new load
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [23:0] shift;
  logic [1:0]  byte_idx;
  logic        xfer;
  logic [15:0] len_next;

  assign xfer     = byte_valid && byte_ready;
  assign len_next = {len[15:8], byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      len        <= '0;
      shift      <= '0;
      byte_idx   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LEN_HI;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            imem_addr  <= BASE_ADDR;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= byte_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= byte_data;
            if (len_next == 16'd0) begin
              state      <= S_DONE;
              byte_ready <= 1'b0;
              cpu_hold   <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              if (32'(len_next) > MAX_WORDS) overflow <= 1'b1;
              byte_idx <= '0;
              state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            shift    <= {shift[15:0], byte_data};
            if (byte_idx == 2'd3) begin
              // Words beyond capacity still pass through WRITE, just without the strobe.
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              imem_we    <= (32'(word_count) < MAX_WORDS);
              imem_addr  <= BASE_ADDR + (ADDR_W'(word_count) << 2);
              imem_wdata <= {shift, byte_data};
            end
          end
        end
        S_WRITE: begin
          imem_we    <= 1'b0;
          word_count <= word_count + 16'd1;
          if ((word_count + 16'd1) == len) begin
            state     <= S_DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state      <= S_DATA;
            byte_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: one full-size and one two-word
// instance share the byte stream; captured writes are compared against a list model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        ready_a, we_a, hold_a, done_a, ovf_a;
  logic [31:0] addr_a, wdata_a;
  logic [15:0] cnt_a;
  logic        ready_b, we_b, hold_b, done_b, ovf_b;
  logic [31:0] addr_b, wdata_b;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] words[$];
  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];

  imem_loader #(.ADDR_W(32), .MAX_WORDS(64), .BASE_ADDR(32'h0)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .cpu_hold(hold_a), .load_done(done_a), .overflow(ovf_a), .word_count(cnt_a)
  );

  imem_loader #(.ADDR_W(32), .MAX_WORDS(2), .BASE_ADDR(32'h0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .cpu_hold(hold_b), .load_done(done_b), .overflow(ovf_b), .word_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every write strobe; a strobe must never coincide with an open byte port.
  always @(negedge clk) begin
    if (we_a) begin
      wa_addr.push_back(addr_a);
      wa_data.push_back(wdata_a);
      chk("ready_in_write_a", 32'(ready_a), 32'd0);
    end
    if (we_b) begin
      wb_addr.push_back(addr_b);
      wb_data.push_back(wdata_b);
      chk("ready_in_write_b", 32'(ready_b), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int pct);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard <= 200) begin
      @(negedge clk);
      byte_valid = ($urandom_range(99) < pct);
      byte_data  = byte_valid ? b : 8'($urandom);
      acc = byte_valid && ready_a;
      @(posedge clk);
      guard++;
    end
    chk("byte_accept_in_budget", 32'(guard <= 200), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_we", 32'(we_a), 32'd0);
    chk("rst_addr", addr_a, 32'd0);
    chk("rst_wdata", wdata_a, 32'd0);
    chk("rst_hold", 32'(hold_a), 32'd1);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_ovf_b", 32'(ovf_b), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
  endtask

  // Model: word i lands at 4*i if i < capacity; every header word is counted.
  task automatic check_writes(input int ln);
    int na = (ln < 64) ? ln : 64;
    int nb = (ln < 2) ? ln : 2;
    chk("write_count_a", 32'(wa_addr.size()), 32'(na));
    for (int i = 0; i < na && i < wa_addr.size(); i++) begin
      chk("addr_a", wa_addr[i], 32'(4 * i));
      chk("data_a", wa_data[i], words[i]);
    end
    chk("write_count_b", 32'(wb_addr.size()), 32'(nb));
    for (int i = 0; i < nb && i < wb_addr.size(); i++) begin
      chk("addr_b", wb_addr[i], 32'(4 * i));
      chk("data_b", wb_data[i], words[i]);
    end
    chk("word_count_a", 32'(cnt_a), 32'(ln));
    chk("word_count_b", 32'(cnt_b), 32'(ln));
    chk("overflow_a", 32'(ovf_a), 32'(ln > 64));
    chk("overflow_b", 32'(ovf_b), 32'(ln > 2));
    chk("done_b", 32'(done_b), 32'd1);
    chk("hold_b", 32'(hold_b), 32'd0);
  endtask

  task automatic run_load(input int pct, input bit mid_start);
    logic [15:0] ln = 16'(words.size());
    logic [31:0] w;
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    pulse_start();
    chk("hold_after_start", 32'(hold_a), 32'd1);
    chk("done_after_start", 32'(done_a), 32'd0);
    chk("ready_len_hi", 32'(ready_a), 32'd1);
    chk("cnt_cleared", 32'(cnt_a), 32'd0);
    chk("ovf_cleared_b", 32'(ovf_b), 32'd0);
    send_byte(ln[15:8], pct);
    send_byte(ln[7:0], pct);
    for (int i = 0; i < int'(ln); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8], pct);
        if (mid_start && i == 0 && k == 1) begin
          pulse_start();
          chk("ready_after_mid_start", 32'(ready_a), 32'd1);
          chk("hold_after_mid_start", 32'(hold_a), 32'd1);
        end
      end
    end
    #1;
    if (ln == 16'd0) begin
      chk("hold_drop_len0", 32'(hold_a), 32'd0);
    end else begin
      chk("we_last_word", 32'(we_a), 32'((int'(ln) - 1) < 64));
      chk("ready_last_write", 32'(ready_a), 32'd0);
      chk("hold_in_last_write", 32'(hold_a), 32'd1);
      @(posedge clk);
      #1;
      chk("hold_after_write", 32'(hold_a), 32'd0);
      chk("we_after_write", 32'(we_a), 32'd0);
    end
    chk("load_done", 32'(done_a), 32'd1);
    chk("ready_in_done", 32'(ready_a), 32'd0);
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    check_writes(int'(ln));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    words = '{32'h24080005, 32'h2009000A};
    run_load(100, 1'b0);

    words.delete();
    run_load(100, 1'b0);

    words.delete();
    repeat (3) words.push_back($urandom);
    run_load(100, 1'b0);

    words.delete();
    repeat (4) words.push_back($urandom);
    run_load(100, 1'b0);
    run_load(30, 1'b0);

    // Reset after the second data byte of the first word.
    words.delete();
    repeat (2) words.push_back($urandom);
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    pulse_start();
    send_byte(8'h00, 100);
    send_byte(8'h02, 100);
    w = words[0];
    send_byte(w[31:24], 100);
    send_byte(w[23:16], 100);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    chk("no_partial_write", 32'(wa_addr.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_load(100, 1'b0);

    words = '{32'h8C0A0010};
    run_load(100, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
